fifo_lfsr_read_checker: RTL
===========================

// Module: fifo_lfsr_read_checker
// PURPOSE
//  Self-checking read-side traffic engine for async_fifo, clocked in the rd_clk domain.
//  - Pops words with an LFSR-throttled rd_en.
//  - Regenerates the expected data stream from a local data LFSR and compares every popped word.
//  - Reports read/error counts and pass/done status.
//  Pairs with a write-side generator that uses the same data LFSR and seed. Used for on-chip
//  and long-run CDC soak testing.
// PARAMETERS
//  DATA_WIDTH     8        FIFO word width; must be <= 16
//  RD_LATENCY     1        rd_clk cycles from rd_en sampled high to rd_data valid; range 1..4
//  CNT_WIDTH      32       width of num_reads, read_count and first_err_idx
//  ERR_WIDTH      16       width of error_count (saturating)
//  DATA_SEED      16'h1234 data LFSR seed; zero is illegal ($error at elaboration)
//  THROTTLE_SEED  16'h5A5A throttle LFSR seed; zero is illegal
// PORTS
//  rd_clk         in   1          checker and FIFO read clock
//  rst_n          in   1          asynchronous active-low reset
//  start          in   1          1-cycle pulse; begins a run (ignored while busy)
//  num_reads      in   CNT_WIDTH  words to pop in this run; latched on start
//  rd_threshold   in   17         pop probability: pop allowed when thr_lfsr < rd_threshold; 17'h10000 = always
//  rd_en          out  1          FIFO pop request
//  rd_data        in   DATA_WIDTH FIFO read data
//  empty          in   1          FIFO empty flag
//  busy           out  1          run in progress
//  done           out  1          run complete; held until next start
//  pass           out  1          done && error_count==0
//  read_count     out  CNT_WIDTH  words compared in this run
//  error_count    out  ERR_WIDTH  mismatches; saturates at all-ones
//  first_err_vld  out  1          a mismatch has been captured this run
//  first_err_idx  out  CNT_WIDTH  read index (0-based) of the first mismatch
// BEHAVIOUR
//  Reset (async on rst_n low, any state, including mid-run):
//  - FSM goes to IDLE; all outputs are 0; rd_en drops immediately.
//  - LFSRs load their seeds; in-flight compares are discarded.
//  LFSR:
//  - 16-bit Fibonacci: fb = s[15]^s[14]^s[12]^s[3]; next = {s[14:0], fb}.
//  - Expected word k = S_k[DATA_WIDTH-1:0], where S_0 = DATA_SEED and S_{k+1} = next(S_k).
//  FSM:
//  - IDLE -> RUN on start. At that edge: latch num_reads and rd_threshold; reload both LFSRs
//    from the seeds; clear counts, first_err_*, done and pass; set busy.
//  - RUN: the throttle LFSR steps every cycle.
//      rd_en = RUN && issued < num_reads && !empty && thr_lfsr < thr_latched
//    rd_en is combinational from registered state and empty.
//  - RUN -> DONE when issued == num_reads and no compare is outstanding.
//    busy=0, done=1, pass as defined above.
//  - DONE -> RUN on start, same actions as IDLE -> RUN.
//  - num_reads == 0: RUN lasts 1 cycle, then done=1, pass=1.
//  - start while busy is ignored.
//  Pop and compare:
//  - A pop is valid only when rd_en is high at the rd_clk edge.
//  - A RD_LATENCY-deep valid shift register tracks outstanding pops.
//  - At the edge where the tap is high: compare rd_data to the expected word, step the data
//    LFSR, and increment read_count.
//  - On a mismatch: increment error_count unless it is at all-ones. If first_err_vld==0,
//    set first_err_vld and first_err_idx = read_count (value before the increment).
//  - Back-to-back pops every cycle are supported (full throughput).
//  FIFO contract: empty reflects every pop accepted on prior edges. The checker never pops
//  when empty=1, and never issues more than num_reads pops.
//  Width rule: read_count and issued never wrap, because num_reads bounds them.
// TESTING
//  1. DATA_SEED=16'h1234; bench FIFO model preloaded with 8'h34, 8'h69, 8'hD3; num_reads=3;
//     rd_threshold=17'h10000 -> 3 consecutive rd_en cycles; done=1, pass=1, read_count=3.
//  2. Same stream with word 1 corrupted to 8'h6A -> error_count=1, first_err_vld=1,
//     first_err_idx=1, pass=0.
//  3. async_fifo (16 deep) plus matching LFSR writer; 5000 words each at thresholds
//     50/50, 80/50 and 50/80 % -> pass=1 and read_count=5000 for all three.
//  4. empty held 1 for 100 cycles mid-run -> rd_en stays 0; then resumes, pass=1.
//  5. rst_n pulsed low mid-run with rd_en high -> all outputs 0 the same cycle;
//     a restart with start yields pass=1.
//  6. num_reads=0 -> done=1 and pass=1 one cycle after start, no rd_en;
//     start pulsed while busy -> ignored.

Source files
------------

// File: rtl/fifo_lfsr_read_checker.sv
// Read-side soak-test engine: pops an async FIFO under LFSR throttling and
// checks every popped word against a locally regenerated LFSR data stream.
module fifo_lfsr_read_checker #(
  parameter int          DATA_WIDTH    = 8,
  parameter int          RD_LATENCY    = 1,
  parameter int          CNT_WIDTH     = 32,
  parameter int          ERR_WIDTH     = 16,
  parameter logic [15:0] DATA_SEED     = 16'h1234,
  parameter logic [15:0] THROTTLE_SEED = 16'h5A5A
) (
  input  logic                  i_rd_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [CNT_WIDTH-1:0]  i_num_reads,
  input  logic [16:0]           i_rd_threshold,
  output logic                  o_rd_en,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  input  logic                  i_empty,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_pass,
  output logic [CNT_WIDTH-1:0]  o_read_count,
  output logic [ERR_WIDTH-1:0]  o_error_count,
  output logic                  o_first_err_vld,
  output logic [CNT_WIDTH-1:0]  o_first_err_idx
);

  generate
    if (DATA_SEED == 16'h0) begin : g_bad_data_seed
      $error("fifo_lfsr_read_checker: DATA_SEED must be nonzero");
    end
    if (THROTTLE_SEED == 16'h0) begin : g_bad_thr_seed
      $error("fifo_lfsr_read_checker: THROTTLE_SEED must be nonzero");
    end
    if (DATA_WIDTH < 1 || DATA_WIDTH > 16) begin : g_bad_width
      $error("fifo_lfsr_read_checker: DATA_WIDTH must be 1..16");
    end
    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
      $error("fifo_lfsr_read_checker: RD_LATENCY must be 1..4");
    end
  endgenerate

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]};
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                 r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0]   r_num;
  logic [16:0]            r_thr_lim;
  logic [15:0]            r_thr_lfsr;
  logic [15:0]            r_data_lfsr;
  logic [CNT_WIDTH-1:0]   r_issued;
  logic [RD_LATENCY:1]    r_vld_pipe;
  logic [CNT_WIDTH-1:0]   r_read_count;
  logic [ERR_WIDTH-1:0]   r_error_count;
  logic                   r_first_err_vld;
  logic [CNT_WIDTH-1:0]   r_first_err_idx;

  logic                   w_run;
  logic                   w_start_ok;
  logic                   w_outstanding;
  logic                   w_tap;
  logic                   w_mismatch;

  assign w_run         = (r_state == S_RUN);
  assign w_start_ok    = i_start && !w_run;
  assign w_outstanding = |r_vld_pipe;
  assign w_tap         = r_vld_pipe[RD_LATENCY];
  assign w_mismatch    = w_tap && (i_rd_data != r_data_lfsr[DATA_WIDTH-1:0]);

  // Pop gate: built only from registered state plus the live empty flag.
  assign o_rd_en = w_run && (r_issued < r_num) && !i_empty &&
                   ({1'b0, r_thr_lfsr} < r_thr_lim);

  always_ff @(posedge i_rd_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (i_start) w_state_nxt = S_RUN;
      S_RUN:          if (r_issued == r_num && !w_outstanding) w_state_nxt = S_DONE;
      default:        w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_rd_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_num           <= '0;
      r_thr_lim       <= '0;
      r_thr_lfsr      <= THROTTLE_SEED;
      r_data_lfsr     <= DATA_SEED;
      r_issued        <= '0;
      r_vld_pipe      <= '0;
      r_read_count    <= '0;
      r_error_count   <= '0;
      r_first_err_vld <= 1'b0;
      r_first_err_idx <= '0;
    end else if (w_start_ok) begin
      r_num           <= i_num_reads;
      r_thr_lim       <= i_rd_threshold;
      r_thr_lfsr      <= THROTTLE_SEED;
      r_data_lfsr     <= DATA_SEED;
      r_issued        <= '0;
      r_vld_pipe      <= '0;
      r_read_count    <= '0;
      r_error_count   <= '0;
      r_first_err_vld <= 1'b0;
      r_first_err_idx <= '0;
    end else if (w_run) begin
      r_thr_lfsr    <= lfsr_next(r_thr_lfsr);
      r_vld_pipe[1] <= o_rd_en;
      for (int i = 2; i <= RD_LATENCY; i++) r_vld_pipe[i] <= r_vld_pipe[i-1];
      if (o_rd_en) r_issued <= r_issued + 1'b1;
      // Data for a pop lands RD_LATENCY edges later; compare at the tap.
      if (w_tap) begin
        r_data_lfsr  <= lfsr_next(r_data_lfsr);
        r_read_count <= r_read_count + 1'b1;
        if (w_mismatch) begin
          if (r_error_count != {ERR_WIDTH{1'b1}}) r_error_count <= r_error_count + 1'b1;
          if (!r_first_err_vld) begin
            r_first_err_vld <= 1'b1;
            r_first_err_idx <= r_read_count;
          end
        end
      end
    end
  end

  assign o_busy          = w_run;
  assign o_done          = (r_state == S_DONE);
  assign o_pass          = o_done && (r_error_count == '0);
  assign o_read_count    = r_read_count;
  assign o_error_count   = r_error_count;
  assign o_first_err_vld = r_first_err_vld;
  assign o_first_err_idx = r_first_err_idx;

endmodule
